// File: rtl/muldiv_unit.sv
// Iterative 16-bit multiply/divide unit.
// Shift-add multiply (unsigned, or signed via magnitudes plus a final negate)
// and restoring divide. One iteration per clock, WIDTH iterations per operation,
// followed by a one-cycle DONE state that issues the register write-back.
module muldiv_unit #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4,
  parameter int CNTBITS = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic [REGBITS-1:0] dest,
  output logic               busy,
  output logic               done,
  output logic               wb_en,
  output logic [REGBITS-1:0] wb_addr,
  output logic [WIDTH-1:0]   wb_data,
  output logic [WIDTH-1:0]   result_hi
);

  localparam logic [1:0] OP_MULU = 2'b00;
  localparam logic [1:0] OP_MULS = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_r;
  logic [1:0]           op_r;
  logic [REGBITS-1:0]   dest_r;
  logic                 neg_r;
  logic [WIDTH-1:0]     acc_r;   // product high half / partial remainder
  logic [WIDTH-1:0]     mq_r;    // multiplier (shifted out) / dividend->quotient
  logic [WIDTH-1:0]     b_r;     // multiplicand magnitude / divisor
  logic [CNTBITS-1:0]   cnt_r;

  logic [WIDTH-1:0]     load_mq_s;
  logic [WIDTH-1:0]     load_b_s;
  logic                 load_neg_s;
  logic [WIDTH:0]       sum_s;
  logic [WIDTH:0]       shift_s;
  logic [WIDTH:0]       diff_s;
  logic [WIDTH-1:0]     acc_nx_s;
  logic [WIDTH-1:0]     mq_nx_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [2*WIDTH-1:0]   prod_fix_s;
  logic [WIDTH-1:0]     lo_s;
  logic [WIDTH-1:0]     hi_s;

  // Operand preparation at start: MULS works on magnitudes, the multiplier
  // goes into the low shift register and the multiplicand into b.
  always_comb begin
    load_mq_s  = src_a;
    load_b_s   = src_b;
    load_neg_s = 1'b0;
    case (op)
      OP_MULU: begin
        load_mq_s = src_b;
        load_b_s  = src_a;
      end
      OP_MULS: begin
        if (src_b[WIDTH-1]) begin
          load_mq_s = -src_b;
        end else begin
          load_mq_s = src_b;
        end
        if (src_a[WIDTH-1]) begin
          load_b_s = -src_a;
        end else begin
          load_b_s = src_a;
        end
        load_neg_s = src_a[WIDTH-1] ^ src_b[WIDTH-1];
      end
      OP_DIVU, OP_REMU: begin
        load_mq_s = src_a;
        load_b_s  = src_b;
      end
      default: begin
        load_mq_s = src_a;
        load_b_s  = src_b;
      end
    endcase
  end

  // One iteration of the shared datapath plus the result formatting used on
  // the final iteration. A zero divisor always "fits", which yields an
  // all-ones quotient and a remainder equal to the dividend.
  always_comb begin
    sum_s    = {1'b0, acc_r} + {1'b0, b_r};
    shift_s  = {acc_r, mq_r[WIDTH-1]};
    diff_s   = shift_s - {1'b0, b_r};
    acc_nx_s = acc_r;
    mq_nx_s  = mq_r;
    case (op_r)
      OP_MULU, OP_MULS: begin
        if (mq_r[0]) begin
          acc_nx_s = sum_s[WIDTH:1];
          mq_nx_s  = {sum_s[0], mq_r[WIDTH-1:1]};
        end else begin
          acc_nx_s = {1'b0, acc_r[WIDTH-1:1]};
          mq_nx_s  = {acc_r[0], mq_r[WIDTH-1:1]};
        end
      end
      OP_DIVU, OP_REMU: begin
        if (!diff_s[WIDTH]) begin
          acc_nx_s = diff_s[WIDTH-1:0];
          mq_nx_s  = {mq_r[WIDTH-2:0], 1'b1};
        end else begin
          acc_nx_s = shift_s[WIDTH-1:0];
          mq_nx_s  = {mq_r[WIDTH-2:0], 1'b0};
        end
      end
      default: begin
        acc_nx_s = acc_r;
        mq_nx_s  = mq_r;
      end
    endcase

    prod_s = {acc_nx_s, mq_nx_s};
    if ((op_r == OP_MULS) && neg_r) begin
      prod_fix_s = -prod_s;
    end else begin
      prod_fix_s = prod_s;
    end

    case (op_r)
      OP_MULU, OP_MULS: begin
        lo_s = prod_fix_s[WIDTH-1:0];
        hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
      end
      OP_DIVU: begin
        lo_s = mq_nx_s;
        hi_s = acc_nx_s;
      end
      OP_REMU: begin
        lo_s = acc_nx_s;
        hi_s = acc_nx_s;
      end
      default: begin
        lo_s = mq_nx_s;
        hi_s = acc_nx_s;
      end
    endcase
  end

  // Control FSM, iteration registers and registered write-back outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      op_r      <= 2'b00;
      dest_r    <= {REGBITS{1'b0}};
      neg_r     <= 1'b0;
      acc_r     <= {WIDTH{1'b0}};
      mq_r      <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      cnt_r     <= {CNTBITS{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      wb_en     <= 1'b0;
      wb_addr   <= {REGBITS{1'b0}};
      wb_data   <= {WIDTH{1'b0}};
      result_hi <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done  <= 1'b0;
          wb_en <= 1'b0;
          if (start) begin
            op_r    <= op;
            dest_r  <= dest;
            neg_r   <= load_neg_s;
            acc_r   <= {WIDTH{1'b0}};
            mq_r    <= load_mq_s;
            b_r     <= load_b_s;
            cnt_r   <= CNTBITS'(WIDTH);
            busy    <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_RUN: begin
          acc_r <= acc_nx_s;
          mq_r  <= mq_nx_s;
          cnt_r <= cnt_r - CNTBITS'(1);
          if (cnt_r == CNTBITS'(1)) begin
            state_r   <= ST_DONE;
            done      <= 1'b1;
            wb_en     <= (dest_r != {REGBITS{1'b0}});
            wb_addr   <= dest_r;
            wb_data   <= lo_s;
            result_hi <= hi_s;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          wb_en   <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done    <= 1'b0;
          wb_en   <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases followed by random
// operations, compared against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [15:0] src_a;
  logic [15:0] src_b;
  logic [3:0]  dest;
  logic        busy;
  logic        done;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic [15:0] result_hi;

  int total;
  int passed;

  muldiv_unit #(.WIDTH(16), .REGBITS(4), .CNTBITS(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .dest(dest),
    .busy(busy), .done(done), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .result_hi(result_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: returns {result_hi, wb_data}
  function automatic logic [31:0] model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    int sa;
    int sb;
    int p;
    logic [31:0] r;
    case (o)
      2'b00: r = {16'h0000, a} * {16'h0000, b};
      2'b01: begin
        sa = $signed(a);
        sb = $signed(b);
        p  = sa * sb;
        r  = p;
      end
      2'b10: r = (b == 16'h0000) ? {a, 16'hFFFF} : {a % b, a / b};
      default: r = (b == 16'h0000) ? {a, a} : {a % b, a % b};
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issue one operation; if ign >= 0 a stray start with junk operands is
  // raised that many cycles into RUN and must be ignored.
  task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] d, input int ign);
    int n;
    logic [31:0] e;
    e = model(o, a, b);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b; dest = d;
    @(posedge clk); #1;
    check("busy_rise", {31'd0, busy}, 32'd1);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      start = (n == ign) ? 1'b1 : 1'b0;
      op    = 2'($urandom);
      src_a = 16'($urandom);
      src_b = 16'($urandom);
      dest  = 4'($urandom);
      @(posedge clk); #1;
      n = n + 1;
    end
    start = 1'b0;
    check("latency", n, 32'd16);
    check("done_pulse", {31'd0, done}, 32'd1);
    check("wb_en", {31'd0, wb_en}, {31'd0, (d != 4'd0)});
    if (d != 4'd0) check("wb_addr", {28'd0, wb_addr}, {28'd0, d});
    check("wb_data", {16'd0, wb_data}, {16'd0, e[15:0]});
    check("result_hi", {16'd0, result_hi}, {16'd0, e[31:16]});
    @(posedge clk); #1;
    check("done_drop", {29'd0, busy, done, wb_en}, 32'd0);
    check("wb_hold", {result_hi, wb_data}, e);
  endtask

  initial begin
    int saw;
    total  = 0;
    passed = 0;
    reset  = 1'b1;
    start  = 1'b0;
    op     = 2'b00;
    src_a  = 16'h0000;
    src_b  = 16'h0000;
    dest   = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctl", {29'd0, busy, done, wb_en}, 32'd0);
    check("reset_data", {result_hi, wb_data}, 32'd0);
    check("reset_addr", {28'd0, wb_addr}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // directed cases
    run_op(2'b00, 16'h1234, 16'h0010, 4'd3, -1);
    check("plan1_data", {result_hi, wb_data}, 32'h0001_2340);
    run_op(2'b01, 16'hFFFD, 16'h0005, 4'd5, -1);
    check("plan2_muls", {result_hi, wb_data}, 32'hFFFF_FFF1);
    run_op(2'b00, 16'hFFFF, 16'hFFFF, 4'd7, -1);
    check("plan2_mulu", {result_hi, wb_data}, 32'hFFFE_0001);
    run_op(2'b10, 16'd100, 16'd7, 4'd2, -1);
    check("plan3_divu", {result_hi, wb_data}, 32'h0002_000E);
    run_op(2'b11, 16'd100, 16'd7, 4'd2, -1);
    run_op(2'b10, 16'h1234, 16'h0000, 4'd4, -1);
    check("plan4_div0", {result_hi, wb_data}, 32'h1234_FFFF);
    run_op(2'b11, 16'h8001, 16'h0000, 4'd6, -1);
    run_op(2'b00, 16'h0102, 16'h0304, 4'd0, -1);
    run_op(2'b01, 16'h8000, 16'h8000, 4'd9, -1);
    run_op(2'b01, 16'h7FFF, 16'h8000, 4'd1, -1);
    run_op(2'b10, 16'hFFFF, 16'h0001, 4'd8, 5);
    run_op(2'b00, 16'h00FF, 16'h0101, 4'd15, 5);

    // abort by asynchronous reset 8 cycles into RUN
    @(negedge clk);
    start = 1'b1; op = 2'b00; src_a = 16'hABCD; src_b = 16'h1234; dest = 4'd10;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("abort_ctl", {29'd0, busy, done, wb_en}, 32'd0);
    check("abort_data", {result_hi, wb_data}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    saw = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (wb_en !== 1'b0 || done !== 1'b0) saw = 1;
    end
    check("abort_no_wb", saw, 32'd0);
    run_op(2'b01, 16'hFF00, 16'h0003, 4'd11, -1);

    // random operations
    for (int i = 0; i < 24; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom);
      rb = (i % 6 == 0) ? 16'h0000 : ((i % 3 == 0) ? 16'($urandom_range(1, 300)) : 16'($urandom));
      run_op(2'($urandom), ra, rb, 4'($urandom), (i % 7 == 0) ? 3 : -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
